// File: rtl/controlador_pisca.sv
// Blink controller: turns one-cycle request pulses into active-low pulses of ON_CYCLES,
// each followed by an OFF_CYCLES high gap, with a saturating queue for overlapping requests.
module controlador_pisca #(
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned ON_CYCLES  = 255,
  parameter int unsigned OFF_CYCLES = 255,
  parameter int unsigned PEND_W     = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p_in,
  output logic              led_out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              drop
);

  localparam logic [CNT_W-1:0]  OnLast  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0]  OffLast = CNT_W'(OFF_CYCLES - 1);
  localparam logic [PEND_W-1:0] PendMax = {PEND_W{1'b1}};

  typedef enum logic [1:0] {StIdle, StOn, StOff} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              drop_q, drop_d;
  logic              led_q, busy_q;

  logic consume_p;  // p_in used directly to start a blink
  logic take_q;     // a queued request starts a blink this cycle
  logic queue_p;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    consume_p = 1'b0;
    take_q    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pend_q != '0) begin
          state_d = StOn;
          cnt_d   = '0;
          take_q  = 1'b1;
        end else if (p_in) begin
          state_d   = StOn;
          cnt_d     = '0;
          consume_p = 1'b1;
        end
      end
      StOn: begin
        if (cnt_q == OnLast) begin
          state_d = StOff;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StOff: begin
        if (cnt_q == OffLast) begin
          cnt_d = '0;
          if (pend_q != '0) begin
            state_d = StOn;
            take_q  = 1'b1;
          end else if (p_in) begin
            state_d   = StOn;
            consume_p = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Queue update: a request not consumed is added; a simultaneous dequeue cancels it out.
  always_comb begin
    pend_d  = pend_q;
    drop_d  = 1'b0;
    queue_p = p_in && !consume_p;
    if (queue_p && !take_q) begin
      if (pend_q == PendMax) begin
        drop_d = 1'b1;
      end else begin
        pend_d = pend_q + PEND_W'(1);
      end
    end else if (!queue_p && take_q) begin
      pend_d = pend_q - PEND_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      pend_q  <= '0;
      drop_q  <= 1'b0;
      led_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      drop_q  <= drop_d;
      led_q   <= (state_d != StOn);
      busy_q  <= (state_d != StIdle);
    end
  end

  assign led_out = led_q;
  assign busy    = busy_q;
  assign pending = pend_q;
  assign drop    = drop_q;

endmodule

// File: tb/tb_controlador_pisca.sv
// Bench for controlador_pisca: directed scenarios plus random pulses, checked against a
// timeline model (position within the ON+OFF blink period and a request count).
module tb_controlador_pisca;

  localparam int ON   = 4;
  localparam int OFF  = 3;
  localparam int PER  = ON + OFF;
  localparam int MAXQ = 3;

  logic       clk;
  logic       rst_n;
  logic       p_in;
  logic       led_out;
  logic       busy;
  logic [1:0] pending;
  logic       drop;

  int errors = 0;
  int checks = 0;

  // Model: m_t = clocks since current blink started (-1 when idle), m_q = queued requests.
  int m_t;
  int m_q;
  bit m_drop;

  controlador_pisca #(
    .CNT_W(8),
    .ON_CYCLES(ON),
    .OFF_CYCLES(OFF),
    .PEND_W(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .p_in(p_in),
    .led_out(led_out),
    .busy(busy),
    .pending(pending),
    .drop(drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".led"}, int'(led_out), (m_t >= 0 && m_t < ON) ? 0 : 1);
    chk({tag, ".busy"}, int'(busy), (m_t >= 0) ? 1 : 0);
    chk({tag, ".pending"}, int'(pending), m_q);
    chk({tag, ".drop"}, int'(drop), int'(m_drop));
  endtask

  task automatic model_reset();
    m_t    = -1;
    m_q    = 0;
    m_drop = 0;
  endtask

  task automatic model_clock(input bit p);
    m_drop = 0;
    if (m_t < 0) begin
      if (p) m_t = 0;
      else if (m_q > 0) begin
        m_q--;
        m_t = 0;
      end
    end else if (m_t == PER - 1) begin
      if (m_q > 0) begin
        m_t = 0;
        if (!p) m_q--;
      end else if (p) m_t = 0;
      else m_t = -1;
    end else begin
      m_t++;
      if (p) begin
        if (m_q == MAXQ) m_drop = 1;
        else m_q++;
      end
    end
  endtask

  task automatic step(input bit p, input string tag);
    @(negedge clk);
    p_in = p;
    @(posedge clk);
    model_clock(p);
    #1;
    chk_all(tag);
  endtask

  task automatic idle_steps(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, tag);
  endtask

  // Advance until the next edge is the last OFF clock of the current blink.
  task automatic wait_last_off(input string tag);
    int n;
    n = 0;
    while (m_t != PER - 1 && n < 40) begin
      step(1'b0, tag);
      n++;
    end
    if (m_t != PER - 1) begin
      checks++;
      errors++;
      $error("FAIL %s timeout observed=%0d expected=%0d", tag, m_t, PER - 1);
    end
  endtask

  task automatic async_reset(input string tag);
    @(negedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk_all(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int low_runs;
  bit prev_led;

  initial begin
    p_in  = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #12;
    chk_all("por");
    rst_n = 1'b1;

    // 1: async reset mid-ON
    step(1'b1, "rst.start");
    idle_steps(2, "rst.on");
    async_reset("rst.mid_on");

    // 2: single blink; count low periods as an independent check
    low_runs = 0;
    prev_led = 1'b1;
    step(1'b1, "single.start");
    for (int i = 0; i < 10; i++) begin
      if (prev_led && !led_out) low_runs++;
      prev_led = led_out;
      step(1'b0, "single");
    end
    chk("single.blinks", low_runs, 1);

    // 3: three queued requests -> four blinks
    low_runs = 0;
    prev_led = 1'b1;
    step(1'b1, "queue.start");
    for (int i = 0; i < 3; i++) step(1'b1, "queue.pulse");
    chk("queue.pend3", int'(pending), 3);
    for (int i = 0; i < 4 * PER + 3; i++) begin
      if (prev_led && !led_out) low_runs++;
      prev_led = led_out;
      step(1'b0, "queue");
    end
    chk("queue.blinks", low_runs, 4);

    // 4: overflow -> drops on 4th and 5th pulses
    step(1'b1, "ovf.start");
    for (int i = 0; i < 3; i++) step(1'b1, "ovf.pulse");
    step(1'b1, "ovf.p4");
    chk("ovf.drop4", int'(drop), 1);
    step(1'b1, "ovf.p5");
    chk("ovf.drop5", int'(drop), 1);
    step(1'b0, "ovf.after");
    chk("ovf.nodrop", int'(drop), 0);
    idle_steps(4 * PER, "ovf");

    // 5: p_in on last OFF clock, pending 0 then pending 2
    step(1'b1, "bnd.start");
    wait_last_off("bnd.wait0");
    step(1'b1, "bnd.p0");
    chk("bnd.on0", int'(led_out), 0);
    chk("bnd.pend0", int'(pending), 0);
    step(1'b1, "bnd.q1");
    step(1'b1, "bnd.q2");
    wait_last_off("bnd.wait2");
    step(1'b1, "bnd.p2");
    chk("bnd.pend2", int'(pending), 2);
    idle_steps(3 * PER + 2, "bnd.drain");

    // 6: reset mid-OFF with pending=2, then one request -> one blink
    step(1'b1, "rec.start");
    step(1'b1, "rec.q1");
    step(1'b1, "rec.q2");
    idle_steps(ON, "rec.toff");
    async_reset("rec.mid_off");
    low_runs = 0;
    prev_led = 1'b1;
    step(1'b1, "rec.p");
    for (int i = 0; i < 2 * PER; i++) begin
      if (prev_led && !led_out) low_runs++;
      prev_led = led_out;
      step(1'b0, "rec");
    end
    chk("rec.blinks", low_runs, 1);

    // Random pulse traffic
    for (int i = 0; i < 400; i++) step(($urandom % 4) == 0, "rand");
    idle_steps(5 * PER, "rand.drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
